ambient_light_conditioner: RTL and testbench
============================================

Name: ambient_light_conditioner

Overview:
Front-end stage that produces the day/night decision consumed by the street light controller's light_sensor input (0 = day, 1 = night). It takes raw ambient-light ADC samples and averages them over a sliding window. It applies threshold hysteresis and a persistence count so that clouds, headlights and sample glitches do not toggle the lamp. A sample watchdog forces a fail-safe night indication (lamp on) if the ADC stops delivering samples.

Parameters:
DATA_W, 8, ADC sample width
AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples)
DARK_TH, 60, average strictly below this counts as dark; must be < BRIGHT_TH
BRIGHT_TH, 100, average strictly above this counts as bright
HOLD_CNT, 8, consecutive qualifying evaluations required before the output flips; must be >= 1
TIMEOUT, 1000000, clk_in cycles without adc_valid before a fault is declared
WD_W, 20, watchdog counter width; must hold TIMEOUT

Ports:
clk_in  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-low reset
adc_data  input  DATA_W  ambient light sample; higher value = brighter
adc_valid  input  1  one-cycle qualifier; every high cycle accepts one sample
light_sensor  output  1  day/night decision, 0 = day, 1 = night
avg_level  output  DATA_W  current window average
avg_valid  output  1  window has been filled since reset or fault
state_change  output  1  one-cycle pulse whenever light_sensor toggles
sensor_fault  output  1  sample watchdog expired

Behaviour:
- Reset (reset low, asynchronous): FSM = DAY; light_sensor, state_change, sensor_fault, avg_valid = 0; avg_level = 0; window, sum, fill count, hold count and watchdog cleared.
- Window: shift register of 2^AVG_LOG2 samples with running sum of width DATA_W+AVG_LOG2. On each accepted sample: sum <= sum + new - oldest, and the window shifts.
- avg_level is registered (sum >> AVG_LOG2). It updates at the same edge as the sum update.
- avg_valid goes to 1 at the edge that accepts the 2^AVG_LOG2-th sample after reset or fault entry.
- Evaluation: a registered eval strobe fires one cycle after each accepted sample while avg_valid = 1. The FSM acts only on eval. Decision latency from the qualifying sample to the output flip is 1 cycle.
- FSM states and transitions:
  - DAY: if avg < DARK_TH, go to DUSK_PEND with hold = 1. If HOLD_CNT = 1, go directly to NIGHT.
  - DUSK_PEND: if avg < DARK_TH, increment hold; when hold reaches HOLD_CNT, go to NIGHT. Otherwise return to DAY with hold cleared.
  - NIGHT: if avg > BRIGHT_TH, go to DAWN_PEND with hold = 1 (same HOLD_CNT = 1 shortcut).
  - DAWN_PEND: if avg > BRIGHT_TH, increment hold; when hold reaches HOLD_CNT, go to DAY. Otherwise return to NIGHT.
  - Averages between the thresholds (inclusive) cause no move from DAY or NIGHT and abort either pending state.
  - FAULT: described under Watchdog below.
- Output mapping:
  - light_sensor = 0 in DAY and DUSK_PEND; 1 in NIGHT, DAWN_PEND and FAULT. It is registered with the state.
  - state_change is high for exactly the cycle light_sensor first shows its new value.
- Watchdog:
  - The counter increments every cycle and clears on adc_valid. It saturates.
  - When it reaches TIMEOUT, enter FAULT from any state. On entry, set sensor_fault = 1, light_sensor = 1, flush the window (sum, fill, avg_valid = 0) and clear hold.
  - If adc_valid is high in the same cycle the count would reach TIMEOUT, the sample wins: no fault.
- FAULT exit: samples are still accepted. The first eval after the window refills moves to NIGHT and clears sensor_fault; normal hysteresis then resumes. No state_change pulse on this exit, since light_sensor stays 1.
- Counters never wrap: hold saturates at HOLD_CNT and the watchdog at TIMEOUT.

Test Plan:
1. Hold reset low, then release -> light_sensor = 0, state_change = 0, sensor_fault = 0, avg_valid = 0, avg_level = 0. Then 3 samples of 200 -> avg_valid still 0.
2. 4 samples of 200 (avg_level = 200, light_sensor 0), then constant 30 -> avg sequence 157, 115, 72, 30. The 4th sample of 30 starts the hold count. light_sensor rises 1 cycle after the 11th sample of 30, with exactly one state_change pulse.
3. From NIGHT, feed steady 80 for 20 samples -> light_sensor stays 1. Then steady 150 -> light_sensor falls after HOLD_CNT evaluations above 100, with one pulse.
4. From DAY, feed 30 until hold = 5, then 200 -> FSM returns to DAY, light_sensor stays 0, no pulse. Repeat with hold = 7 (one short of HOLD_CNT) -> same result.
5. With TIMEOUT = 100 and no adc_valid for 100 cycles -> sensor_fault = 1, light_sensor = 1 and one pulse at cycle 100. Then 4 samples of 200 -> sensor_fault = 0, state NIGHT, and DAY after 8 more evaluations. A sample arriving on cycle 100 -> no fault.
6. Assert reset mid DUSK_PEND (hold = 4) -> immediate DAY, all outputs 0, window cleared. After release, 8 samples of 30 -> no flip until 4 fill samples plus 8 qualifying evaluations.

Source files
------------

// File: rtl/ambient_light_conditioner.sv
// Ambient-light front end: sliding-window average, hysteresis with persistence,
// and a sample watchdog that forces a fail-safe night indication.
module ambient_light_conditioner #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned AVG_LOG2  = 2,
   parameter int unsigned DARK_TH   = 60,
   parameter int unsigned BRIGHT_TH = 100,
   parameter int unsigned HOLD_CNT  = 8,
   parameter int unsigned TIMEOUT   = 1000000,
   parameter int unsigned WD_W      = 20
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   output logic              light_sensor,
   output logic [DATA_W-1:0] avg_level,
   output logic              avg_valid,
   output logic              state_change,
   output logic              sensor_fault
);

   localparam int unsigned DEPTH  = 1 << AVG_LOG2;
   localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
   localparam int unsigned FILL_W = AVG_LOG2 + 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_CNT + 1);

   typedef enum logic [2:0] {StDay, StDuskPend, StNight, StDawnPend, StFault} state_e;

   logic [DATA_W-1:0] win_q [DEPTH];
   logic [SUM_W-1:0]  sum_q, sum_nxt;
   logic [FILL_W-1:0] fill_q;
   logic              fill_last;
   logic              eval_q;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              timeout_hit;
   logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
   state_e            state_q, state_d;
   logic              fault_d, light_d, dark, bright;

   assign sum_nxt   = sum_q + SUM_W'(adc_data) - SUM_W'(win_q[DEPTH-1]);
   assign fill_last = (fill_q == FILL_W'(DEPTH - 1));

   // A sample on the same cycle the count would reach TIMEOUT keeps the sensor alive.
   assign timeout_hit = !adc_valid && (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      wd_d = wd_q;
      if (adc_valid) begin
         wd_d = '0;
      end else if (wd_q != WD_W'(TIMEOUT)) begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
         sum_q     <= '0;
         fill_q    <= '0;
         avg_valid <= 1'b0;
         avg_level <= '0;
         eval_q    <= 1'b0;
      end else if (timeout_hit) begin
         for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
         sum_q     <= '0;
         fill_q    <= '0;
         avg_valid <= 1'b0;
         avg_level <= '0;
         eval_q    <= 1'b0;
      end else begin
         eval_q <= adc_valid && (avg_valid || fill_last);
         if (adc_valid) begin
            win_q[0] <= adc_data;
            for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
            sum_q     <= sum_nxt;
            avg_level <= sum_nxt[SUM_W-1:AVG_LOG2];
            if (!avg_valid) begin
               fill_q    <= fill_q + FILL_W'(1);
               avg_valid <= fill_last;
            end
         end
      end
   end

   assign dark     = (avg_level < DATA_W'(DARK_TH));
   assign bright   = (avg_level > DATA_W'(BRIGHT_TH));
   assign hold_inc = (hold_q == HOLD_W'(HOLD_CNT)) ? hold_q : hold_q + HOLD_W'(1);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      fault_d = sensor_fault;
      if (timeout_hit) begin
         state_d = StFault;
         hold_d  = '0;
         fault_d = 1'b1;
      end else if (eval_q) begin
         unique case (state_q)
            StDay: begin
               if (dark) begin
                  state_d = (HOLD_CNT == 1) ? StNight : StDuskPend;
                  hold_d  = (HOLD_CNT == 1) ? '0 : HOLD_W'(1);
               end
            end
            StDuskPend: begin
               if (!dark) begin
                  state_d = StDay;
                  hold_d  = '0;
               end else if (hold_inc == HOLD_W'(HOLD_CNT)) begin
                  state_d = StNight;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_inc;
               end
            end
            StNight: begin
               if (bright) begin
                  state_d = (HOLD_CNT == 1) ? StDay : StDawnPend;
                  hold_d  = (HOLD_CNT == 1) ? '0 : HOLD_W'(1);
               end
            end
            StDawnPend: begin
               if (!bright) begin
                  state_d = StNight;
                  hold_d  = '0;
               end else if (hold_inc == HOLD_W'(HOLD_CNT)) begin
                  state_d = StDay;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_inc;
               end
            end
            StFault: begin
               // Refilled window: resume from the safe side without a visible toggle.
               state_d = StNight;
               hold_d  = '0;
               fault_d = 1'b0;
            end
            default: begin
               state_d = StDay;
               hold_d  = '0;
            end
         endcase
      end
      light_d = (state_d == StNight) || (state_d == StDawnPend) || (state_d == StFault);
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q      <= StDay;
         hold_q       <= '0;
         light_sensor <= 1'b0;
         state_change <= 1'b0;
         sensor_fault <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         light_sensor <= light_d;
         state_change <= (light_d != light_sensor);
         sensor_fault <= fault_d;
      end
   end

endmodule

// File: tb/tb_ambient_light_conditioner.sv
// Bench for ambient_light_conditioner: directed stimulus, an event-level reference
// model compared every cycle, and hand-computed literal checkpoints.
module tb_ambient_light_conditioner;

   localparam int TO   = 100;
   localparam int HOLD = 8;
   localparam int DARK = 60;
   localparam int BRT  = 100;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic [7:0] adc_data;
   logic       adc_valid;
   logic       light_sensor;
   logic [7:0] avg_level;
   logic       avg_valid;
   logic       state_change;
   logic       sensor_fault;

   ambient_light_conditioner #(
      .DATA_W    (8),
      .AVG_LOG2  (2),
      .DARK_TH   (DARK),
      .BRIGHT_TH (BRT),
      .HOLD_CNT  (HOLD),
      .TIMEOUT   (TO),
      .WD_W      (20)
   ) dut (
      .clk_in       (clk_in),
      .reset        (rst_n),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .light_sensor (light_sensor),
      .avg_level    (avg_level),
      .avg_valid    (avg_valid),
      .state_change (state_change),
      .sensor_fault (sensor_fault)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;
   bit run_cmp  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: last four samples, a night flag and a streak of qualifying evaluations.
   int q[$];
   int idle     = 0;
   int m_avg    = 0;
   int streak   = 0;
   bit m_valid  = 0;
   bit m_pend   = 0;
   bit m_night  = 0;
   bit m_fault  = 0;
   bit m_change = 0;
   bit was_night;
   int s;

   task automatic judge(input int avg);
      if (m_fault) begin
         m_fault = 0;
         m_night = 1;
         streak  = 0;
      end else if (!m_night) begin
         if (avg < DARK) begin
            streak++;
            if (streak >= HOLD) begin m_night = 1; streak = 0; end
         end else streak = 0;
      end else begin
         if (avg > BRT) begin
            streak++;
            if (streak >= HOLD) begin m_night = 0; streak = 0; end
         end else streak = 0;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk_in or negedge rst_n);
         if (!rst_n) begin
            q.delete();
            idle = 0; m_avg = 0; streak = 0;
            m_valid = 0; m_pend = 0; m_night = 0; m_fault = 0; m_change = 0;
         end else begin
            was_night = m_night;
            if (!adc_valid && idle == TO - 1) begin
               m_fault = 1; m_night = 1; streak = 0;
               q.delete();
               m_avg = 0; m_valid = 0; m_pend = 0; idle = TO;
            end else begin
               if (m_pend) judge(m_avg);
               if (adc_valid) begin
                  idle = 0;
                  q.push_front(int'(adc_data));
                  if (q.size() > 4) void'(q.pop_back());
                  s = 0;
                  foreach (q[i]) s += q[i];
                  m_avg   = s / 4;
                  m_valid = (q.size() == 4);
                  m_pend  = m_valid;
               end else begin
                  if (idle < TO) idle++;
                  m_pend = 0;
               end
            end
            m_change = (m_night != was_night);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_in);
         if (run_cmp) begin
            chk("cyc_light_sensor", 32'(light_sensor), 32'(m_night));
            chk("cyc_sensor_fault", 32'(sensor_fault), 32'(m_fault));
            chk("cyc_avg_valid",    32'(avg_valid),    32'(m_valid));
            chk("cyc_avg_level",    32'(avg_level),    32'(m_avg));
            chk("cyc_state_change", 32'(state_change), 32'(m_change));
            if (state_change) pulses++;
         end
      end
   end

   task automatic send(input int v);
      @(negedge clk_in);
      adc_data  = 8'(v);
      adc_valid = 1'b1;
      @(negedge clk_in);
      adc_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "time limit");
   end

   int p0;

   initial begin
      rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_light",  32'(light_sensor), 0);
      chk("rst_change", 32'(state_change), 0);
      chk("rst_fault",  32'(sensor_fault), 0);
      chk("rst_avgv",   32'(avg_valid),    0);
      chk("rst_avg",    32'(avg_level),    0);
      run_cmp = 1'b1;
      #2 rst_n = 1'b1;

      // Partial window stays invalid, then fills.
      repeat (3) send(200);
      chk("t1_avgv_partial", 32'(avg_valid), 0);
      send(200);
      chk("t2_avg200", 32'(avg_level), 200);
      chk("t2_avgv",   32'(avg_valid), 1);
      chk("t2_light0", 32'(light_sensor), 0);

      // Dusk: averages ramp down; the 4th dark sample starts the hold.
      p0 = pulses;
      send(30); chk("t2_avg157", 32'(avg_level), 157);
      send(30); chk("t2_avg115", 32'(avg_level), 115);
      send(30); chk("t2_avg72",  32'(avg_level), 72);
      send(30); chk("t2_avg30",  32'(avg_level), 30);
      repeat (6) send(30);
      @(negedge clk_in);
      chk("t2_no_flip_10", 32'(light_sensor), 0);
      send(30);
      chk("t2_no_flip_yet", 32'(light_sensor), 0);
      @(negedge clk_in);
      chk("t2_night",  32'(light_sensor), 1);
      chk("t2_pulse1", 32'(pulses - p0), 1);

      // Mid-band light holds NIGHT; bright light flips after HOLD evaluations.
      repeat (20) send(80);
      chk("t3_hold_night", 32'(light_sensor), 1);
      p0 = pulses;
      repeat (8) send(150);
      @(negedge clk_in);
      chk("t3_not_yet_day", 32'(light_sensor), 1);
      send(150);
      @(negedge clk_in);
      chk("t3_day",    32'(light_sensor), 0);
      chk("t3_pulse1", 32'(pulses - p0), 1);

      // Aborted dusk at hold 5 and at hold 7.
      p0 = pulses;
      repeat (8) send(30);
      send(200);
      repeat (3) @(negedge clk_in);
      chk("t4_abort5_light", 32'(light_sensor), 0);
      repeat (10) send(30);
      send(200);
      repeat (3) @(negedge clk_in);
      chk("t4_abort7_light", 32'(light_sensor), 0);
      chk("t4_no_pulse",     32'(pulses - p0), 0);

      // Watchdog fault from DAY, recovery through NIGHT, then DAY.
      p0 = pulses;
      send(90);
      repeat (99) @(negedge clk_in);
      chk("t5_no_fault_99", 32'(sensor_fault), 0);
      @(negedge clk_in);
      chk("t5_fault",       32'(sensor_fault), 1);
      chk("t5_fault_light", 32'(light_sensor), 1);
      chk("t5_fault_avgv",  32'(avg_valid),    0);
      chk("t5_fault_pulse", 32'(pulses - p0),  1);
      repeat (4) send(200);
      @(negedge clk_in);
      chk("t5_fault_clear", 32'(sensor_fault), 0);
      chk("t5_night_after", 32'(light_sensor), 1);
      chk("t5_exit_nopulse", 32'(pulses - p0), 1);
      repeat (7) send(200);
      @(negedge clk_in);
      chk("t5_still_night", 32'(light_sensor), 1);
      send(200);
      @(negedge clk_in);
      chk("t5_day", 32'(light_sensor), 0);

      // A sample landing exactly on the timeout cycle prevents the fault.
      send(200);
      repeat (99) @(negedge clk_in);
      adc_data = 8'd200; adc_valid = 1'b1;
      @(negedge clk_in);
      adc_valid = 1'b0;
      chk("t5_sample_wins", 32'(sensor_fault), 0);

      // Reset in the middle of a pending dusk.
      repeat (7) send(30);
      @(negedge clk_in);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_light",  32'(light_sensor), 0);
      chk("t6_rst_fault",  32'(sensor_fault), 0);
      chk("t6_rst_avgv",   32'(avg_valid),    0);
      chk("t6_rst_avg",    32'(avg_level),    0);
      chk("t6_rst_change", 32'(state_change), 0);
      @(negedge clk_in);
      #2 rst_n = 1'b1;
      repeat (8) send(30);
      @(negedge clk_in);
      chk("t6_no_flip_8", 32'(light_sensor), 0);
      repeat (3) send(30);
      @(negedge clk_in);
      chk("t6_night", 32'(light_sensor), 1);

      run_cmp = 1'b0;
      @(negedge clk_in);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
